iram_loader: RTL

//  Write side of the instruction RAM: receives a program image as a byte stream (from UART RX), assembles 16-bit

---
 rtl/iram_pkg.sv | 46 ++++
 rtl/iram_loader_byte_pack.sv | 65 ++++++
 rtl/iram_loader.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/iram_pkg.sv
// Shared IRAM definitions: widths, loader state encoding and small data helpers
// used by the loader and its byte assembler.
package iram_pkg;

    localparam int IRAM_ADDR_W = 8;
    localparam int IRAM_DATA_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GET_LEN = 3'd1,
        ST_GET_B0  = 3'd2,
        ST_GET_B1  = 3'd3,
        ST_WRITE   = 3'd4,
        ST_GET_CHK = 3'd5
    } loader_state_t;

    // States in which the loader is willing to take a byte from the stream.
    function automatic logic is_rx_state(input loader_state_t st);
        logic rx;
        case (st)
            ST_GET_LEN: rx = 1'b1;
            ST_GET_B0:  rx = 1'b1;
            ST_GET_B1:  rx = 1'b1;
            ST_GET_CHK: rx = 1'b1;
            default:    rx = 1'b0;
        endcase
        return rx;
    endfunction

    function automatic logic [IRAM_DATA_W-1:0] pack_word(input logic [7:0] first_b,
                                                         input logic [7:0] second_b,
                                                         input logic       hi_first);
        logic [IRAM_DATA_W-1:0] w;
        if (hi_first) begin
            w = {first_b, second_b};
        end else begin
            w = {second_b, first_b};
        end
        return w;
    endfunction

    function automatic logic [7:0] xor_accum(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/iram_loader_byte_pack.sv
// Two-byte to 16-bit word assembler with selectable byte order; with
// IRAM_LOADER_CHECKSUM_EN it also keeps a running XOR of every data byte.
module byte_pack
    import iram_pkg::*;
#(
    parameter int HI_FIRST = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   b0_en,
    input  logic                   b1_en,
    input  logic [7:0]             byte_in,
    output logic [IRAM_DATA_W-1:0] word
`ifdef IRAM_LOADER_CHECKSUM_EN
   ,output logic [7:0]             chk_xor
`endif
);

    logic [7:0]             first_r;
    logic [IRAM_DATA_W-1:0] word_r;

    // Hold the first byte of a word, then form the word when the second arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            first_r <= 8'h00;
            word_r  <= 16'h0000;
        end else begin
            if (clr) begin
                first_r <= 8'h00;
            end else if (b0_en) begin
                first_r <= byte_in;
            end else begin
                first_r <= first_r;
            end
            if (b1_en) begin
                word_r <= pack_word(first_r, byte_in, (HI_FIRST != 0));
            end else begin
                word_r <= word_r;
            end
        end
    end

    assign word = word_r;

`ifdef IRAM_LOADER_CHECKSUM_EN
    logic [7:0] xor_r;

    // Running XOR over all data bytes of the current image.
    always_ff @(posedge clk) begin
        if (rst) begin
            xor_r <= 8'h00;
        end else if (clr) begin
            xor_r <= 8'h00;
        end else if (b0_en || b1_en) begin
            xor_r <= xor_accum(xor_r, byte_in);
        end else begin
            xor_r <= xor_r;
        end
    end

    assign chk_xor = xor_r;
`endif

endmodule

// File: rtl/iram_loader.sv
// IRAM write-side loader: takes a length-prefixed byte stream, packs 16-bit words and
// writes them at consecutive addresses while holding the CPU. Option: IRAM_LOADER_CHECKSUM_EN.
module iram_loader
    import iram_pkg::*;
#(
    parameter int ADDR_W    = IRAM_ADDR_W,
    parameter int BASE_ADDR = 0,
    parameter int HI_FIRST  = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_start,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic                   rx_ready,
    output logic                   wea,
    output logic [ADDR_W-1:0]      iaddr,
    output logic [IRAM_DATA_W-1:0] idataout,
    output logic                   cpu_hold,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    // Word counter must hold 2**ADDR_W as well as any 8-bit length.
    localparam int REM_W = ((ADDR_W > 8) ? ADDR_W : 8) + 1;

    loader_state_t     state_r;
    loader_state_t     state_nxt_s;
    logic [ADDR_W-1:0] addr_r;
    logic [REM_W-1:0]  rem_r;
    logic [REM_W-1:0]  rem_load_s;
    logic              rx_ready_r;
    logic              wea_r;
    logic              busy_r;
    logic              cpu_hold_r;
    logic              done_r;
    logic              err_r;

    logic              xfer_s;
    logic              start_s;
    logic              len_en_s;
    logic              b0_en_s;
    logic              b1_en_s;
    logic              wr_s;
    logic              fin_ok_s;
    logic              fin_err_s;
`ifdef IRAM_LOADER_CHECKSUM_EN
    logic [7:0]        chk_xor_s;
`endif

    assign xfer_s     = rx_valid & rx_ready_r;
    assign rem_load_s = (rx_data == 8'd0) ? (REM_W'(1) << ADDR_W) : REM_W'(rx_data);

    byte_pack #(
        .HI_FIRST (HI_FIRST)
    ) u_byte_pack (
        .clk     (clk),
        .rst     (rst),
        .clr     (start_s),
        .b0_en   (b0_en_s),
        .b1_en   (b1_en_s),
        .byte_in (rx_data),
        .word    (idataout)
`ifdef IRAM_LOADER_CHECKSUM_EN
       ,.chk_xor (chk_xor_s)
`endif
    );

    // Next-state decode and one-cycle control strobes.
    always_comb begin
        state_nxt_s = state_r;
        start_s     = 1'b0;
        len_en_s    = 1'b0;
        b0_en_s     = 1'b0;
        b1_en_s     = 1'b0;
        wr_s        = 1'b0;
        fin_ok_s    = 1'b0;
        fin_err_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (load_start) begin
                    state_nxt_s = ST_GET_LEN;
                    start_s     = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_GET_LEN: begin
                if (xfer_s) begin
                    state_nxt_s = ST_GET_B0;
                    len_en_s    = 1'b1;
                end else begin
                    state_nxt_s = ST_GET_LEN;
                end
            end
            ST_GET_B0: begin
                if (xfer_s) begin
                    state_nxt_s = ST_GET_B1;
                    b0_en_s     = 1'b1;
                end else begin
                    state_nxt_s = ST_GET_B0;
                end
            end
            ST_GET_B1: begin
                if (xfer_s) begin
                    state_nxt_s = ST_WRITE;
                    b1_en_s     = 1'b1;
                end else begin
                    state_nxt_s = ST_GET_B1;
                end
            end
            ST_WRITE: begin
                wr_s = 1'b1;
                if (rem_r == REM_W'(1)) begin
`ifdef IRAM_LOADER_CHECKSUM_EN
                    state_nxt_s = ST_GET_CHK;
`else
                    state_nxt_s = ST_IDLE;
                    fin_ok_s    = 1'b1;
`endif
                end else begin
                    state_nxt_s = ST_GET_B0;
                end
            end
            ST_GET_CHK: begin
`ifdef IRAM_LOADER_CHECKSUM_EN
                if (xfer_s) begin
                    state_nxt_s = ST_IDLE;
                    if (rx_data == chk_xor_s) begin
                        fin_ok_s = 1'b1;
                    end else begin
                        fin_err_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_GET_CHK;
                end
`else
                state_nxt_s = ST_IDLE;
`endif
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, handshake/write strobes and status flags, all registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            rx_ready_r <= 1'b0;
            wea_r      <= 1'b0;
            busy_r     <= 1'b0;
            cpu_hold_r <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            rx_ready_r <= is_rx_state(state_nxt_s);
            wea_r      <= (state_nxt_s == ST_WRITE);
            if (start_s) begin
                busy_r     <= 1'b1;
                cpu_hold_r <= 1'b1;
                done_r     <= 1'b0;
                err_r      <= 1'b0;
            end else if (fin_ok_s) begin
                busy_r     <= 1'b0;
                cpu_hold_r <= 1'b0;
                done_r     <= 1'b1;
            end else if (fin_err_s) begin
                busy_r     <= 1'b0;
                cpu_hold_r <= 1'b0;
                err_r      <= 1'b1;
            end else begin
                busy_r     <= busy_r;
                cpu_hold_r <= cpu_hold_r;
            end
        end
    end

    // Write address and words-remaining counter; the address wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_r <= ADDR_W'(BASE_ADDR);
            rem_r  <= {REM_W{1'b0}};
        end else begin
            if (start_s) begin
                addr_r <= ADDR_W'(BASE_ADDR);
            end else if (wr_s) begin
                addr_r <= addr_r + ADDR_W'(1);
            end else begin
                addr_r <= addr_r;
            end
            if (len_en_s) begin
                rem_r <= rem_load_s;
            end else if (wr_s) begin
                rem_r <= rem_r - REM_W'(1);
            end else begin
                rem_r <= rem_r;
            end
        end
    end

    assign rx_ready = rx_ready_r;
    assign wea      = wea_r;
    assign iaddr    = addr_r;
    assign busy     = busy_r;
    assign cpu_hold = cpu_hold_r;
    assign done     = done_r;
    assign err      = err_r;

endmodule
